// File: rtl/drop_sequencer.sv
// drop_sequencer: captures a height, computes floor(sqrt(height*65536)) one bit per
// cycle, derives t_act = root>>1, compares it to t_lim and sequences a timed drop pulse.
// Optional post-drop lockout is built only when DROP_LOCKOUT_EN is defined.
module drop_sequencer #(
  parameter int DROP_HOLD   = 4,
  parameter int LOCKOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  height,
  input  logic [15:0] t_lim,
  input  logic        drop_en,
  output logic        busy,
  output logic        done,
  output logic [15:0] t_act,
  output logic        drop_activated
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SQRT = 3'd1,
    S_CMP  = 3'd2,
    S_HOLD = 3'd3
`ifdef DROP_LOCKOUT_EN
    ,
    S_LOCK = 3'd4
`endif
  } state_e;

  localparam logic [15:0] HOLD_LAST = 16'(DROP_HOLD - 1);
`ifdef DROP_LOCKOUT_EN
  localparam logic [15:0] LOCK_LAST = 16'(LOCKOUT_CYC - 1);
`endif

  state_e      state_q, state_d;
  logic [23:0] rad_q, rad_d;
  logic [13:0] rem_q, rem_d;
  logic [11:0] root_q, root_d;
  logic [3:0]  iter_q, iter_d;
  logic [15:0] t_lim_q, t_lim_d;
  logic        drop_en_q, drop_en_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
`ifdef DROP_LOCKOUT_EN
  logic [15:0] lock_cnt_q, lock_cnt_d;
`endif
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] t_act_q, t_act_d;
  logic        drop_q, drop_d;

  // Restoring square root step: bring down two radicand bits, try subtracting 4*root+1.
  logic [15:0] rem_sh;
  logic [15:0] trial;
  logic [15:0] t_act_new;
  logic        drop_ok;
  logic        sqrt_last;
  logic        hold_last;

  assign rem_sh    = {rem_q, rad_q[23:22]};
  assign trial     = {2'b00, root_q, 2'b01};
  assign t_act_new = {5'b00000, root_q[11:1]};
  assign drop_ok   = drop_en_q && (t_act_new < t_lim_q);
  assign sqrt_last = (iter_q == 4'd11);
  assign hold_last = (hold_cnt_q == HOLD_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SQRT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SQRT: begin
        if (sqrt_last) begin
          state_d = S_CMP;
        end else begin
          state_d = S_SQRT;
        end
      end
      S_CMP: begin
        if (drop_ok) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (hold_last) begin
`ifdef DROP_LOCKOUT_EN
          state_d = S_LOCK;
`else
          state_d = S_IDLE;
`endif
        end else begin
          state_d = S_HOLD;
        end
      end
`ifdef DROP_LOCKOUT_EN
      S_LOCK: begin
        if (lock_cnt_q == LOCK_LAST) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_LOCK;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    rad_d      = rad_q;
    rem_d      = rem_q;
    root_d     = root_q;
    iter_d     = iter_q;
    t_lim_d    = t_lim_q;
    drop_en_d  = drop_en_q;
    hold_cnt_d = hold_cnt_q;
`ifdef DROP_LOCKOUT_EN
    lock_cnt_d = lock_cnt_q;
`endif
    t_act_d    = t_act_q;
    done_d     = 1'b0;
    busy_d     = (state_d != S_IDLE);
    drop_d     = (state_d == S_HOLD);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rad_d     = {height, 16'h0000};
          rem_d     = 14'd0;
          root_d    = 12'd0;
          iter_d    = 4'd0;
          t_lim_d   = t_lim;
          drop_en_d = drop_en;
        end else begin
          iter_d = iter_q;
        end
      end
      S_SQRT: begin
        rad_d  = {rad_q[21:0], 2'b00};
        iter_d = iter_q + 4'd1;
        if (rem_sh >= trial) begin
          rem_d  = 14'(rem_sh - trial);
          root_d = {root_q[10:0], 1'b1};
        end else begin
          rem_d  = rem_sh[13:0];
          root_d = {root_q[10:0], 1'b0};
        end
      end
      S_CMP: begin
        done_d     = 1'b1;
        t_act_d    = t_act_new;
        hold_cnt_d = 16'd0;
      end
      S_HOLD: begin
        hold_cnt_d = hold_cnt_q + 16'd1;
`ifdef DROP_LOCKOUT_EN
        lock_cnt_d = 16'd0;
`endif
      end
`ifdef DROP_LOCKOUT_EN
      S_LOCK: begin
        lock_cnt_d = lock_cnt_q + 16'd1;
      end
`endif
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad_q      <= 24'd0;
      rem_q      <= 14'd0;
      root_q     <= 12'd0;
      iter_q     <= 4'd0;
      t_lim_q    <= 16'd0;
      drop_en_q  <= 1'b0;
      hold_cnt_q <= 16'd0;
`ifdef DROP_LOCKOUT_EN
      lock_cnt_q <= 16'd0;
`endif
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      t_act_q    <= 16'd0;
      drop_q     <= 1'b0;
    end else begin
      rad_q      <= rad_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      iter_q     <= iter_d;
      t_lim_q    <= t_lim_d;
      drop_en_q  <= drop_en_d;
      hold_cnt_q <= hold_cnt_d;
`ifdef DROP_LOCKOUT_EN
      lock_cnt_q <= lock_cnt_d;
`endif
      busy_q     <= busy_d;
      done_q     <= done_d;
      t_act_q    <= t_act_d;
      drop_q     <= drop_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign t_act          = t_act_q;
  assign drop_activated = drop_q;

endmodule
